lcd_bus_receiver: RTL and testbench

- Synthesizable receiving end of the 4-bit character-LCD bus (E/RS/RW/DAT[3:0]) that our display driver transmits on.
- Reassembles nibbles into bytes, runs the HD44780-style init sequence, decodes commands, and keeps a 32-character shadow of the screen.
- Used as an on-chip loopback/monitor and as the DUT-side model in display-driver benches.
- Exports the screen as a 256-bit string in the same layout as the driver's input: char 0 at [255:248].

---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_sync_edge.sv | 47 ++++
 rtl/lcd_bus_receiver.sv | 215 +++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared opcodes, FSM encodings, DDRAM line bases and address
//                stepping for the 4-bit character-LCD bus receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_ENTRY     = 8'h04;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] c_INIT_4BIT   = 8'h20;

    localparam logic [6:0] c_LINE1_BASE = 7'h00;
    localparam logic [6:0] c_LINE2_BASE = 7'h40;
    localparam logic [6:0] c_LINE_LAST  = 7'h27;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_MODE8  = 2'd0;
    localparam state_t c_ST_NIB_HI = 2'd1;
    localparam state_t c_ST_NIB_LO = 2'd2;

    // Each line is 0x28 deep; stepping past either end jumps to the other line.
    function automatic logic [6:0] step_addr(input logic [6:0] addr,
                                             input logic       inc,
                                             input logic [6:0] line2_base);
        logic [6:0] last1;
        logic [6:0] last2;
        last1 = c_LINE1_BASE + c_LINE_LAST;
        last2 = line2_base + c_LINE_LAST;
        if (inc) begin
            if (addr == last1)      return line2_base;
            else if (addr == last2) return c_LINE1_BASE;
            else                    return addr + 7'd1;
        end else begin
            if (addr == c_LINE1_BASE)    return last2;
            else if (addr == line2_base) return last1;
            else                         return addr - 7'd1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_sync_edge
//  Description : Two-flop synchronizer for E plus its side-band bus, with
//                falling-edge detection on the synchronized E.
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_sync_edge #(
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_e,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_e_sync,
    output logic              o_e_fall,
    output logic [DATA_W-1:0] o_data_sync
);

    logic              r_e_meta;
    logic              r_e_sync;
    logic              r_e_prev;
    logic [DATA_W-1:0] r_d_meta;
    logic [DATA_W-1:0] r_d_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_meta <= 1'b0;
            r_e_sync <= 1'b0;
            r_e_prev <= 1'b0;
            r_d_meta <= '0;
            r_d_sync <= '0;
        end else begin
            r_e_meta <= i_e;
            r_e_sync <= r_e_meta;
            r_e_prev <= r_e_sync;
            r_d_meta <= i_data;
            r_d_sync <= r_d_meta;
        end
    end

    assign o_e_sync    = r_e_sync;
    assign o_e_fall    = r_e_prev & ~r_e_sync;
    assign o_data_sync = r_d_sync;

endmodule
`default_nettype wire

// File: rtl/lcd_bus_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_bus_receiver
//  Description : 4-bit HD44780-style bus receiver: nibble reassembly, init,
//                command decode, busy/read-back and a 32-char screen shadow.
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter int         BUSY_CYCLES  = 40,
    parameter int         CLEAR_CYCLES = 1600,
    parameter logic [6:0] LINE2_BASE   = c_LINE2_BASE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lcd_e,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic [3:0]   lcd_dat_in,
    output logic [3:0]   lcd_dat_out,
    output logic         lcd_dat_oe,
    output logic [255:0] frame,
    output logic         byte_valid,
    output logic [7:0]   byte_data,
    output logic         byte_rs,
    output logic [6:0]   ddram_addr,
    output logic         busy,
    output logic         four_bit,
    output logic         overrun
);

    localparam int c_MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_BUSY_LOAD  = c_CNT_W'(BUSY_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CLEAR_LOAD = c_CNT_W'(CLEAR_CYCLES);

    logic               w_e_sync;
    logic               w_fall;
    logic               w_rs;
    logic               w_rw;
    logic [3:0]         w_dat;
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_byte_done;
    logic               w_mode8_byte;
    logic               w_latch_hi;
    logic [7:0]         w_byte;
    logic               w_byte_rs;
    logic [3:0]         r_hi_nib;
    logic               r_hi_rs;
    logic               r_hi_rw;
    logic [c_CNT_W-1:0] r_busy_cnt;
    logic               w_busy;
    logic               w_busy_hot;
    logic [6:0]         r_addr;
    logic               r_inc;
    logic [7:0]         r_chars [0:31];
    logic               w_map_hit;
    logic [4:0]         w_map_idx;
    logic [6:0]         w_line2_off;
    logic               r_four_bit;
    logic               r_overrun;
    logic               r_byte_valid;
    logic [7:0]         r_byte_data;
    logic               r_byte_rs;
    logic               r_dat_oe;
    logic [3:0]         r_dat_out;

    lcd_sync_edge #(
        .DATA_W (6)
    ) u_sync (
        .clk         (clk),
        .rst         (rst),
        .i_e         (lcd_e),
        .i_data      ({lcd_rs, lcd_rw, lcd_dat_in}),
        .o_e_sync    (w_e_sync),
        .o_e_fall    (w_fall),
        .o_data_sync ({w_rs, w_rw, w_dat})
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_MODE8;
        else     r_state <= w_state_nxt;
    end

    // Low nibble completes with the RS/RW captured on the high nibble.
    always_comb begin
        w_state_nxt  = r_state;
        w_byte_done  = 1'b0;
        w_mode8_byte = 1'b0;
        w_latch_hi   = 1'b0;
        w_byte       = 8'h00;
        w_byte_rs    = 1'b0;
        case (r_state)
            c_ST_MODE8: begin
                if (w_fall && !w_rw) begin
                    w_byte_done  = 1'b1;
                    w_mode8_byte = 1'b1;
                    w_byte       = {w_dat, 4'h0};
                    w_byte_rs    = w_rs;
                    if ({w_dat, 4'h0} == c_INIT_4BIT) w_state_nxt = c_ST_NIB_HI;
                end
            end
            c_ST_NIB_HI: begin
                if (w_fall) begin
                    w_latch_hi  = 1'b1;
                    w_state_nxt = c_ST_NIB_LO;
                end
            end
            c_ST_NIB_LO: begin
                if (w_fall) begin
                    w_state_nxt = c_ST_NIB_HI;
                    if (!r_hi_rw) begin
                        w_byte_done = 1'b1;
                        w_byte      = {r_hi_nib, w_dat};
                        w_byte_rs   = r_hi_rs;
                    end
                end
            end
            default: w_state_nxt = c_ST_MODE8;
        endcase
    end

    assign w_busy      = (r_busy_cnt != '0);
    assign w_busy_hot  = (r_busy_cnt > c_CNT_W'(1));
    assign w_line2_off = r_addr - LINE2_BASE;

    always_comb begin
        w_map_hit = 1'b0;
        w_map_idx = 5'd0;
        if (r_addr < 7'd16) begin
            w_map_hit = 1'b1;
            w_map_idx = r_addr[4:0];
        end else if (r_addr >= LINE2_BASE && w_line2_off < 7'd16) begin
            w_map_hit = 1'b1;
            w_map_idx = {1'b1, w_line2_off[3:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi_nib     <= 4'h0;
            r_hi_rs      <= 1'b0;
            r_hi_rw      <= 1'b0;
            r_busy_cnt   <= '0;
            r_addr       <= 7'h00;
            r_inc        <= 1'b1;
            r_four_bit   <= 1'b0;
            r_overrun    <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= 8'h00;
            r_byte_rs    <= 1'b0;
            r_dat_oe     <= 1'b0;
            r_dat_out    <= 4'h0;
            for (int i = 0; i < 32; i++) r_chars[i] <= 8'h20;
        end else begin
            r_byte_valid <= w_byte_done;
            r_dat_oe     <= w_e_sync & w_rw;
            if (w_e_sync && w_rw)
                r_dat_out <= (r_state == c_ST_NIB_LO) ? r_addr[3:0] : {w_busy, r_addr[6:4]};
            else
                r_dat_out <= 4'h0;
            if (w_latch_hi) begin
                r_hi_nib <= w_dat;
                r_hi_rs  <= w_rs;
                r_hi_rw  <= w_rw;
            end
            if (w_busy) r_busy_cnt <= r_busy_cnt - c_CNT_W'(1);
            if (w_byte_done) begin
                r_byte_data <= w_byte;
                r_byte_rs   <= w_byte_rs;
                if (w_mode8_byte) begin
                    if (w_byte == c_INIT_4BIT) r_four_bit <= 1'b1;
                end else begin
                    if (w_busy_hot) r_overrun <= 1'b1;
                    r_busy_cnt <= c_BUSY_LOAD;
                    if (w_byte_rs) begin
                        if (w_map_hit) r_chars[w_map_idx] <= w_byte;
                        r_addr <= step_addr(r_addr, r_inc, LINE2_BASE);
                    end else if (w_byte == CMD_CLEAR) begin
                        for (int i = 0; i < 32; i++) r_chars[i] <= 8'h20;
                        r_addr     <= 7'h00;
                        r_inc      <= 1'b1;
                        r_busy_cnt <= c_CLEAR_LOAD;
                    end else if (w_byte[7:1] == CMD_HOME[7:1]) begin
                        r_addr     <= 7'h00;
                        r_busy_cnt <= c_CLEAR_LOAD;
                    end else if (w_byte[7:2] == CMD_ENTRY[7:2]) begin
                        r_inc <= w_byte[1];
                    end else if ((w_byte & CMD_SET_DDRAM) != 8'h00) begin
                        r_addr <= w_byte[6:0];
                    end
                end
            end
        end
    end

    // Char 0 occupies the top byte of the frame.
    for (genvar gi = 0; gi < 32; gi++) begin : g_frame
        assign frame[255-8*gi -: 8] = r_chars[gi];
    end

    assign lcd_dat_out = r_dat_out;
    assign lcd_dat_oe  = r_dat_oe;
    assign byte_valid  = r_byte_valid;
    assign byte_data   = r_byte_data;
    assign byte_rs     = r_byte_rs;
    assign ddram_addr  = r_addr;
    assign busy        = w_busy;
    assign four_bit    = r_four_bit;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_bus_receiver
//  Description : Self-checking bench for lcd_bus_receiver using a table of
//                byte writes plus directed init/clear/read/reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_bus_receiver;

    localparam int c_BUSY  = 40;
    localparam int c_CLEAR = 1600;

    logic         clk = 1'b0;
    logic         rst;
    logic         lcd_e;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [3:0]   lcd_dat_in;
    logic [3:0]   lcd_dat_out;
    logic         lcd_dat_oe;
    logic [255:0] frame;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_rs;
    logic [6:0]   ddram_addr;
    logic         busy;
    logic         four_bit;
    logic         overrun;

    int checks   = 0;
    int failures = 0;
    int bv_cnt   = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [6:0] addr;
        int         idx;
        logic [7:0] ch;
    } vec_t;

    vec_t vecs [20];

    lcd_bus_receiver #(
        .BUSY_CYCLES  (c_BUSY),
        .CLEAR_CYCLES (c_CLEAR),
        .LINE2_BASE   (7'h40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_dat_in  (lcd_dat_in),
        .lcd_dat_out (lcd_dat_out),
        .lcd_dat_oe  (lcd_dat_oe),
        .frame       (frame),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_rs     (byte_rs),
        .ddram_addr  (ddram_addr),
        .busy        (busy),
        .four_bit    (four_bit),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (byte_valid) bv_cnt++;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] char_at(input int idx);
        return frame[255-8*idx -: 8];
    endfunction

    task automatic strobe(input logic rs, input logic rw, input logic [3:0] nib);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_dat_in = nib;
        @(negedge clk);
        lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        strobe(rs, 1'b0, b[7:4]);
        strobe(rs, 1'b0, b[3:0]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout actual=1 expected=0");
        end
    endtask

    // Counts busy-high samples starting two cycles after the byte strobe.
    task automatic measure_busy(input string name, input int exp);
        int n = 0;
        while (n < 5000) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk(name, n, exp);
    endtask

    task automatic read_nib(output logic [3:0] nib, output logic oe_hi, output logic oe_lo);
        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b1;
        @(negedge clk);
        lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        nib   = lcd_dat_out;
        oe_hi = lcd_dat_oe;
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
        oe_lo = lcd_dat_oe;
        lcd_rw = 1'b0;
    endtask

    task automatic do_init();
        strobe(1'b0, 1'b0, 4'h3);
        strobe(1'b0, 1'b0, 4'h3);
        strobe(1'b0, 1'b0, 4'h3);
        chk("four_bit_before_0x20", four_bit, 1'b0);
        strobe(1'b0, 1'b0, 4'h2);
    endtask

    initial begin
        logic [3:0] nib;
        logic       oe_hi;
        logic       oe_lo;
        int         bv0;

        vecs[0]  = '{1'b1, 8'h41, 7'h01,  0, 8'h41};
        vecs[1]  = '{1'b1, 8'h42, 7'h02,  1, 8'h42};
        vecs[2]  = '{1'b0, 8'hC0, 7'h40, -1, 8'h00};
        vecs[3]  = '{1'b1, 8'h5A, 7'h41, 16, 8'h5A};
        vecs[4]  = '{1'b0, 8'hA7, 7'h27, -1, 8'h00};
        vecs[5]  = '{1'b1, 8'h78, 7'h40, 16, 8'h5A};
        vecs[6]  = '{1'b1, 8'h79, 7'h41, 16, 8'h79};
        vecs[7]  = '{1'b0, 8'h04, 7'h41, -1, 8'h00};
        vecs[8]  = '{1'b1, 8'h6D, 7'h40, 17, 8'h6D};
        vecs[9]  = '{1'b1, 8'h6E, 7'h27, 16, 8'h6E};
        vecs[10] = '{1'b0, 8'h80, 7'h00, -1, 8'h00};
        vecs[11] = '{1'b1, 8'h70, 7'h67,  0, 8'h70};
        vecs[12] = '{1'b0, 8'h06, 7'h67, -1, 8'h00};
        vecs[13] = '{1'b1, 8'h71, 7'h00,  0, 8'h70};
        vecs[14] = '{1'b0, 8'h8F, 7'h0F, -1, 8'h00};
        vecs[15] = '{1'b1, 8'h72, 7'h10, 15, 8'h72};
        vecs[16] = '{1'b0, 8'hCF, 7'h4F, -1, 8'h00};
        vecs[17] = '{1'b1, 8'h73, 7'h50, 31, 8'h73};
        vecs[18] = '{1'b0, 8'h02, 7'h00,  1, 8'h42};
        vecs[19] = '{1'b0, 8'h28, 7'h00, 16, 8'h6E};

        rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_dat_in = 4'h0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_frame", frame, {32{8'h20}});
        chk("rst_addr", ddram_addr, 7'h00);
        chk("rst_flags", {busy, four_bit, overrun, byte_valid, byte_rs}, 5'b0);
        chk("rst_byte_data", byte_data, 8'h00);
        chk("rst_read_port", {lcd_dat_oe, lcd_dat_out}, 5'b0);

        do_init();
        chk("init_four_bit", four_bit, 1'b1);
        chk("init_bv_count", bv_cnt, 4);
        chk("init_frame", frame, {32{8'h20}});
        chk("init_byte_data", byte_data, 8'h20);
        chk("init_not_busy", busy, 1'b0);

        // 0x80 with an explicit latency check on the low nibble.
        strobe(1'b0, 1'b0, 4'h8);
        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_dat_in = 4'h0;
        @(negedge clk);
        lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        lcd_e = 1'b0;
        @(negedge clk);
        chk("lat_bv_cyc1", byte_valid, 1'b0);
        @(negedge clk);
        chk("lat_bv_cyc2", byte_valid, 1'b0);
        @(negedge clk);
        chk("lat_bv_cyc3", byte_valid, 1'b1);
        chk("lat_byte_data", byte_data, 8'h80);
        @(negedge clk);
        chk("lat_bv_cyc4", byte_valid, 1'b0);
        measure_busy("busy_len_cmd", c_BUSY - 2);

        for (int i = 0; i < 20; i++) begin
            send_byte(vecs[i].rs, vecs[i].data);
            chk($sformatf("vec%0d_data", i), byte_data, vecs[i].data);
            chk($sformatf("vec%0d_rs", i), byte_rs, vecs[i].rs);
            chk($sformatf("vec%0d_addr", i), ddram_addr, vecs[i].addr);
            if (vecs[i].idx >= 0)
                chk($sformatf("vec%0d_char", i), char_at(vecs[i].idx), vecs[i].ch);
            wait_idle();
        end
        chk("no_overrun_yet", overrun, 1'b0);

        send_byte(1'b0, 8'h01);
        measure_busy("busy_len_clear", c_CLEAR - 2);
        chk("clear_frame", frame, {32{8'h20}});
        chk("clear_addr", ddram_addr, 7'h00);

        send_byte(1'b0, 8'h01);
        send_byte(1'b1, 8'h51);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_char0", char_at(0), 8'h51);
        chk("ovr_char16", char_at(16), 8'h20);
        chk("ovr_addr", ddram_addr, 7'h01);
        chk("ovr_busy", busy, 1'b1);
        wait_idle();

        send_byte(1'b0, 8'h90);
        bv0 = bv_cnt;
        read_nib(nib, oe_hi, oe_lo);
        chk("rd_hi_nib", nib, 4'h9);
        chk("rd_hi_oe_high", oe_hi, 1'b1);
        chk("rd_hi_oe_low", oe_lo, 1'b0);
        read_nib(nib, oe_hi, oe_lo);
        chk("rd_lo_nib", nib, 4'h0);
        chk("rd_lo_oe_high", oe_hi, 1'b1);
        chk("rd_lo_oe_low", oe_lo, 1'b0);
        chk("rd_no_bv", bv_cnt, bv0);
        chk("rd_addr", ddram_addr, 7'h10);
        wait_idle();

        strobe(1'b1, 1'b0, 4'h4);
        bv0 = bv_cnt;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_four_bit", four_bit, 1'b0);
        chk("mid_rst_overrun", overrun, 1'b0);
        chk("mid_rst_addr", ddram_addr, 7'h00);
        do_init();
        send_byte(1'b0, 8'h80);
        chk("mid_rst_bv_count", bv_cnt - bv0, 5);
        chk("mid_rst_byte", byte_data, 8'h80);
        chk("mid_rst_addr_after", ddram_addr, 7'h00);
        chk("mid_rst_frame", frame, {32{8'h20}});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
